// File: rtl/interp_output_packer.sv
// Rounds, shifts and clips rows of four signed samples into pixels, packs ROWS rows per
// block and hands blocks out through a two-entry ping-pong buffer. Optional: INTERP_PACKER_SAT_CNT_EN.
module interp_output_packer #(
   parameter int IN_W  = 14,
   parameter int OUT_W = 8,
   parameter int SHIFT = 6,
   parameter int ROWS  = 4
) (
   input  logic                      CLK,
   input  logic                      RST_ASYNC,
   input  logic                      CLEAR,
   input  logic                      IN_VALID,
   output logic                      IN_READY,
   input  logic signed [IN_W-1:0]    IN_S0,
   input  logic signed [IN_W-1:0]    IN_S1,
   input  logic signed [IN_W-1:0]    IN_S2,
   input  logic signed [IN_W-1:0]    IN_S3,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY,
   output logic [ROWS*4*OUT_W-1:0]   OUT_BLOCK,
   output logic                      OUT_CLIP,
`ifdef INTERP_PACKER_SAT_CNT_EN
   output logic [15:0]               SAT_COUNT,
`endif
   output logic [1:0]                STATE_DBG
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high
   // (and CLEAR is low); valid never depends combinationally on ready in this block.

   localparam int ROW_W = 4 * OUT_W;
   localparam int BLK_W = ROWS * ROW_W;
   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int OFFSET = (1 << SHIFT) >> 1;
   localparam logic signed [IN_W:0] OFF_V = (IN_W+1)'(OFFSET);
   localparam logic signed [IN_W:0] MAX_R = (IN_W+1)'((1 << OUT_W) - 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [BLK_W-1:0] buf_q [2];
   logic [1:0]       clip_q;

   logic signed [IN_W-1:0] samp [4];
   logic signed [IN_W:0]   t_w  [4];
   logic signed [IN_W:0]   r_w  [4];
   logic [3:0]             clip_bits;
   logic [ROW_W-1:0]       row_word;
   logic                   row_clip;
   logic                   accept;
   logic                   out_hs;
   logic                   blk_done;
   logic                   first_row;

   assign samp[0] = IN_S0;
   assign samp[1] = IN_S1;
   assign samp[2] = IN_S2;
   assign samp[3] = IN_S3;

   // Column 0 lands in the most significant byte of the row word.
   always_comb begin
      row_word  = '0;
      clip_bits = '0;
      for (int c = 0; c < 4; c++) begin
         t_w[c] = $signed({samp[c][IN_W-1], samp[c]}) + OFF_V;
         r_w[c] = t_w[c] >>> SHIFT;
         if (r_w[c][IN_W]) begin
            row_word[(4-c)*OUT_W-1 -: OUT_W] = '0;
            clip_bits[c] = 1'b1;
         end else if (r_w[c] > MAX_R) begin
            row_word[(4-c)*OUT_W-1 -: OUT_W] = '1;
            clip_bits[c] = 1'b1;
         end else begin
            row_word[(4-c)*OUT_W-1 -: OUT_W] = r_w[c][OUT_W-1:0];
         end
      end
   end

   assign row_clip  = |clip_bits;
   assign IN_READY  = (state_q != TWO);
   assign OUT_VALID = (state_q != EMPTY);
   assign accept    = IN_VALID && IN_READY && !CLEAR;
   assign out_hs    = OUT_VALID && OUT_READY && !CLEAR;
   assign first_row = (row_cnt_q == '0);
   assign blk_done  = accept && (row_cnt_q == LAST_ROW);
   assign OUT_BLOCK = buf_q[rd_ptr_q];
   assign OUT_CLIP  = clip_q[rd_ptr_q];
   assign STATE_DBG = state_q;

   always_ff @(posedge CLK or posedge RST_ASYNC) begin
      if (RST_ASYNC) begin
         state_q   <= EMPTY;
         row_cnt_q <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (CLEAR) begin
         state_d   = EMPTY;
         row_cnt_d = '0;
         wr_ptr_d  = 1'b0;
         rd_ptr_d  = 1'b0;
      end else begin
         if (accept) begin
            row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
         end
         if (blk_done) begin
            wr_ptr_d = ~wr_ptr_q;
         end
         if (out_hs) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({blk_done, out_hs})
            2'b10: begin
               case (state_q)
                  EMPTY:   state_d = ONE;
                  ONE:     state_d = TWO;
                  default: state_d = state_q;
               endcase
            end
            2'b01: begin
               case (state_q)
                  TWO:     state_d = ONE;
                  ONE:     state_d = EMPTY;
                  default: state_d = state_q;
               endcase
            end
            default: state_d = state_q;
         endcase
      end
   end

   // The fill buffer never aliases the presented one while OUT_VALID is high.
   always_ff @(posedge CLK or posedge RST_ASYNC) begin
      if (RST_ASYNC) begin
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         clip_q   <= '0;
      end else if (accept) begin
         for (int r = 0; r < ROWS; r++) begin
            if (row_cnt_q == CNT_W'(r)) begin
               buf_q[wr_ptr_q][BLK_W-1-r*ROW_W -: ROW_W] <= row_word;
            end
         end
         clip_q[wr_ptr_q] <= first_row ? row_clip : (clip_q[wr_ptr_q] | row_clip);
      end
   end

`ifdef INTERP_PACKER_SAT_CNT_EN
   logic [15:0] sat_q;
   logic [2:0]  n_clip;
   logic [16:0] sat_sum;

   assign n_clip  = 3'(clip_bits[0]) + 3'(clip_bits[1]) + 3'(clip_bits[2]) + 3'(clip_bits[3]);
   assign sat_sum = {1'b0, sat_q} + 17'(n_clip);
   assign SAT_COUNT = sat_q;

   always_ff @(posedge CLK or posedge RST_ASYNC) begin
      if (RST_ASYNC) begin
         sat_q <= '0;
      end else if (CLEAR) begin
         sat_q <= '0;
      end else if (accept) begin
         sat_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
   end
`else
   // No clip statistics in this build.
`endif

endmodule

// File: tb/tb_interp_output_packer.sv
// Randomized bench for interp_output_packer with a queue-based block model and directed
// literal checks; honours INTERP_PACKER_SAT_CNT_EN when defined.
module tb_interp_output_packer;

   logic                clk;
   logic                rst;
   logic                clear;
   logic                in_valid;
   logic                in_ready;
   logic signed [13:0]  s0, s1, s2, s3;
   logic                out_valid;
   logic                out_ready;
   logic [127:0]        out_block;
   logic                out_clip;
   logic [1:0]          state_dbg;
   logic                in_valid4;
   logic                in_ready4;
   logic                out_valid4;
   logic [31:0]         out_block4;
   logic                out_clip4;
   logic [1:0]          state_dbg4;
`ifdef INTERP_PACKER_SAT_CNT_EN
   logic [15:0]         sat_count;
   logic [15:0]         sat_count4;
`endif

   int checks = 0;
   int errors = 0;

   interp_output_packer dut (
      .CLK(clk), .RST_ASYNC(rst), .CLEAR(clear),
      .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_S0(s0), .IN_S1(s1), .IN_S2(s2), .IN_S3(s3),
      .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .OUT_BLOCK(out_block), .OUT_CLIP(out_clip),
`ifdef INTERP_PACKER_SAT_CNT_EN
      .SAT_COUNT(sat_count),
`endif
      .STATE_DBG(state_dbg)
   );

   interp_output_packer #(.SHIFT(4), .ROWS(1)) dut4 (
      .CLK(clk), .RST_ASYNC(rst), .CLEAR(clear),
      .IN_VALID(in_valid4), .IN_READY(in_ready4),
      .IN_S0(s0), .IN_S1(s1), .IN_S2(s2), .IN_S3(s3),
      .OUT_VALID(out_valid4), .OUT_READY(1'b1),
      .OUT_BLOCK(out_block4), .OUT_CLIP(out_clip4),
`ifdef INTERP_PACKER_SAT_CNT_EN
      .SAT_COUNT(sat_count4),
`endif
      .STATE_DBG(state_dbg4)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int ref_pix(input int x, input int sh, output bit clipped);
      int d, t, r;
      d = 1 << sh;
      t = x + d / 2;
      if (t >= 0) r = t / d;
      else        r = -((-t + d - 1) / d);
      clipped = (r < 0) || (r > 255);
      if (r < 0)        ref_pix = 0;
      else if (r > 255) ref_pix = 255;
      else              ref_pix = r;
   endfunction

   logic [127:0] exp_q[$];
   bit           exp_clip_q[$];
   logic [31:0]  part_rows [4];
   int           part_cnt;
   bit           part_clip;
   int           exp_sat;

   task automatic model_reset();
      exp_q.delete();
      exp_clip_q.delete();
      part_cnt  = 0;
      part_clip = 0;
      exp_sat   = 0;
   endtask

   initial model_reset();

   always @(negedge clk) begin
      int           sv [4];
      int           p;
      bit           c;
      bit           rc;
      int           nc;
      logic [31:0]  rw;
      logic [127:0] blk;
      bit           hs;
      bit           acc;
      if (rst) model_reset();
      chk("in_ready", in_ready, exp_q.size() < 2);
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         chk("out_block", out_block, exp_q[0]);
         chk("out_clip", out_clip, exp_clip_q[0]);
      end
`ifdef INTERP_PACKER_SAT_CNT_EN
      chk("sat_count", sat_count, exp_sat);
`endif
      if (!rst) begin
         if (clear) begin
            model_reset();
         end else begin
            hs  = out_ready && (exp_q.size() > 0);
            acc = in_valid && (exp_q.size() < 2);
            if (hs) begin
               void'(exp_q.pop_front());
               void'(exp_clip_q.pop_front());
            end
            if (acc) begin
               sv[0] = int'(s0); sv[1] = int'(s1); sv[2] = int'(s2); sv[3] = int'(s3);
               rc = 0;
               nc = 0;
               for (int i = 0; i < 4; i++) begin
                  p = ref_pix(sv[i], 6, c);
                  rw[31-8*i -: 8] = 8'(p);
                  rc = rc | c;
                  nc += int'(c);
               end
               part_rows[part_cnt] = rw;
               part_clip = (part_cnt == 0) ? rc : (part_clip | rc);
               part_cnt++;
               exp_sat = (exp_sat + nc > 65535) ? 65535 : exp_sat + nc;
               if (part_cnt == 4) begin
                  for (int r = 0; r < 4; r++) blk[127-32*r -: 32] = part_rows[r];
                  exp_q.push_back(blk);
                  exp_clip_q.push_back(part_clip);
                  part_cnt = 0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_row(input int base);
      s0 = 14'((base + 0) * 64);
      s1 = 14'((base + 1) * 64);
      s2 = 14'((base + 2) * 64);
      s3 = 14'((base + 3) * 64);
   endtask

   task automatic push_row(input int a, input int b, input int c, input int d);
      bit acc;
      bit done;
      s0 = 14'(a); s1 = 14'(b); s2 = 14'(c); s3 = 14'(d);
      in_valid = 1'b1;
      done = 0;
      for (int i = 0; i < 64 && !done; i++) begin
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) done = 1;
      end
      in_valid = 1'b0;
      chk("push_row_timeout", done, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit pc;
      int k;
      int cyc;
      bit acc;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
      s0 = '0; s1 = '0; s2 = '0; s3 = '0;
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_block", out_block, 128'h0);
      chk("rst_out_clip", out_clip, 1'b0);
      chk("rst_state", state_dbg, 2'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      chk("pin_model_64", ref_pix(64, 6, pc), 1);
      chk("pin_model_8191", ref_pix(8191, 6, pc), 128);
      chk("pin_model_neg", ref_pix(-100, 6, pc), 0);
      chk("pin_model_neg_clip", pc, 1'b1);
      chk("pin_model_31", ref_pix(31, 6, pc), 0);

      // all samples 64 -> every byte 01
      repeat (4) push_row(64, 64, 64, 64);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_block", out_block, {16{8'h01}});
      chk("t1_clip", out_clip, 1'b0);
      @(posedge clk); #1;

      // mixed row with low clip
      repeat (4) push_row(-100, 31, 32, 8191);
      chk("t2_valid", out_valid, 1'b1);
      chk("t2_block", out_block, {4{32'h00000180}});
      chk("t2_clip", out_clip, 1'b1);
      @(posedge clk); #1;

      // SHIFT=4, single-row instance
      s0 = 14'(8191); s1 = 14'(16); s2 = 14'(0); s3 = -14'sd1;
      in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      chk("s4_valid", out_valid4, 1'b1);
      chk("s4_block", out_block4, 32'hFF010000);
      chk("s4_clip", out_clip4, 1'b1);
`ifdef INTERP_PACKER_SAT_CNT_EN
      chk("s4_sat", sat_count4, 16'd1);
`endif
      @(posedge clk); #1;

      // backpressure: 12 rows with OUT_READY low
      out_ready = 1'b0;
      k = 0; cyc = 0;
      set_row(0);
      in_valid = 1'b1;
      while (k < 8 && cyc < 60) begin
         acc = in_ready;
         @(posedge clk); #1;
         cyc++;
         if (acc) begin k++; set_row(4 * k); end
      end
      chk("bp_accepts", k, 8);
      chk("bp_in_ready_low", in_ready, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_still_stalled", in_ready, 1'b0);
      chk("bp_block0_byte", out_block[127:120], 8'h00);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_ready", in_ready, 1'b1);
      chk("bp_block1_valid", out_valid, 1'b1);
      chk("bp_block1_byte", out_block[127:120], 8'h10);
      while (k < 12 && cyc < 120) begin
         acc = in_ready;
         @(posedge clk); #1;
         cyc++;
         if (acc) begin k++; set_row(4 * k); end
      end
      in_valid = 1'b0;
      chk("bp_total_accepts", k, 12);
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("bp_drained", out_valid, 1'b0);

      // CLEAR with a pending block and a partial block
      out_ready = 1'b0;
      for (int r = 0; r < 6; r++) push_row(r * 64, 64, 128, 192);
      chk("clr_pending", out_valid, 1'b1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("clr_out_valid", out_valid, 1'b0);
      chk("clr_in_ready", in_ready, 1'b1);
      for (int r = 0; r < 4; r++) begin
         set_row(60 + 4 * r);
         push_row(int'(s0), int'(s1), int'(s2), int'(s3));
      end
      chk("clr_fresh_valid", out_valid, 1'b1);
      chk("clr_first_byte", out_block[127:120], 8'h3C);
      chk("clr_last_byte", out_block[7:0], 8'h4B);

      // asynchronous reset while a block is presented
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_out_block", out_block, 128'h0);
      chk("arst_in_ready", in_ready, 1'b1);
`ifdef INTERP_PACKER_SAT_CNT_EN
      chk("arst_sat", sat_count, 16'h0);
`endif
      #4 rst = 1'b0;
      @(posedge clk); #1;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         clear     = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 1) == 1) begin
            s0 = 14'($urandom); s1 = 14'($urandom); s2 = 14'($urandom); s3 = 14'($urandom);
         end else begin
            s0 = 14'($urandom_range(0, 16300)); s1 = 14'($urandom_range(0, 16300));
            s2 = 14'($urandom_range(0, 16300)); s3 = 14'($urandom_range(0, 16300));
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      clear = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("final_empty", out_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
